// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: two valid/ready producer streams, one registered consumer stream and the shared mux select.
interface mux2_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_ready;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_sel;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_sel
    );
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin 2:1 arbiter with bounded burst lock and a one-deep output register.
// Defining ARB_STATS_EN adds saturating per-port fired-beat counters beats0_o/beats1_o.
module mux2_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    mux2_rr_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      beats0_o,
    output logic [15:0]      beats1_o
`endif
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

    logic              load, own_v, oth_v, keep, fire, g;
    logic              out_valid_q, out_valid_d, out_sel_q, out_sel_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // The owner keeps the grant only mid-burst and below the cap, unless the other port is idle
    always_comb begin
        load        = !out_valid_q || bus.out_ready;
        own_v       = out_sel_q ? bus.in1_valid : bus.in0_valid;
        oth_v       = out_sel_q ? bus.in0_valid : bus.in1_valid;
        keep        = own_v && cnt_q != '0 && (cnt_q < MAX_C || !oth_v);
        g           = keep ? out_sel_q : (oth_v ? !out_sel_q : out_sel_q);
        fire        = !rst && load && (own_v || oth_v);
        out_valid_d = load ? fire : out_valid_q;
        out_sel_d   = fire ? g : out_sel_q;
        out_data_d  = fire ? (g ? bus.in1_data : bus.in0_data) : out_data_q;
        cnt_d       = !load ? cnt_q :
                      !fire ? '0 :
                      g != out_sel_q ? CNT_W'(1) :
                      cnt_q == MAX_C ? MAX_C : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b1;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in0_ready = fire && !g;
    assign bus.in1_ready = fire && g;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

`ifdef ARB_STATS_EN
    logic [15:0] beats0_q, beats1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beats0_q <= '0;
            beats1_q <= '0;
        end else begin
            if (fire && !g && beats0_q != 16'hFFFF) beats0_q <= beats0_q + 16'd1;
            if (fire && g && beats1_q != 16'hFFFF) beats1_q <= beats1_q + 16'd1;
        end
    end

    assign beats0_o = beats0_q;
    assign beats1_o = beats1_q;
`endif
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: scoreboard bench for mux2_rr_arbiter; expected {sel,data} beats queued at handshake, popped at output.
module tb_mux2_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
`ifdef ARB_STATS_EN
    logic [15:0] beats0, beats1;
`endif

    mux2_rr_arbiter_if #(.DATA_W(8)) bus ();

    mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef ARB_STATS_EN
        ,
        .beats0_o(beats0),
        .beats1_o(beats1)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data = '0;
        bus.in1_data = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in0_data = 8'h01;
        bus.in1_data = 8'h02;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            n_chk++;
            if ({bus.out_valid, bus.out_data, bus.out_sel} !== {1'b0, 8'h00, 1'b1}) begin
                n_fail++;
                $display("FAIL rst_state: got v=%b d=%h s=%b expected v=0 d=00 s=1", bus.out_valid, bus.out_data, bus.out_sel);
            end
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_ready: got %b%b expected 00", bus.in0_ready, bus.in1_ready);
            end
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_first_grant: got %b%b expected 10", bus.in0_ready, bus.in1_ready);
        end
        @(posedge clk);
        #2;
        n_chk++;
        if ({bus.out_valid, bus.out_data, bus.out_sel} !== {1'b1, 8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_first_beat: got v=%b d=%h s=%b expected v=1 d=01 s=0", bus.out_valid, bus.out_data, bus.out_sel);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            bus.in0_valid = 1'b0;
            bus.in1_valid = k < 5;
            bus.in1_data = 8'h11 + 8'(k);
            #1;
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready} !== {1'b0, k < 5}) begin
                n_fail++;
                $display("FAIL single_ready k=%0d: got %b%b expected 0%b", k, bus.in0_ready, bus.in1_ready, k < 5);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_out: got beat %h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_sel, bus.out_data} !== e) begin
                        n_fail++;
                        $display("FAIL single_out: got %h expected %h", {bus.out_sel, bus.out_data}, e);
                    end
                end
            end
            if (k > 0) begin
                n_chk++;
                if ({bus.out_valid, bus.out_sel} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL single_cont k=%0d: got v=%b s=%b expected 11", k, bus.out_valid, bus.out_sel);
                end
            end
            if (k < 5) exp_q.push_back({1'b1, 8'h11 + 8'(k)});
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        int n0 = 0, n1 = 0;
        logic g, act;
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            g = ((k / 4) % 2) == 1;
            act = k < 16;
            bus.in0_valid = act;
            bus.in1_valid = act;
            bus.in0_data = 8'hA0 + 8'(n0);
            bus.in1_data = 8'hB0 + 8'(n1);
            #1;
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready} !== {act && !g, act && g}) begin
                n_fail++;
                $display("FAIL ctn_ready k=%0d: got %b%b expected %b%b", k, bus.in0_ready, bus.in1_ready, act && !g, act && g);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ctn_out: got beat %h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_sel, bus.out_data} !== e) begin
                        n_fail++;
                        $display("FAIL ctn_out k=%0d: got %h expected %h", k, {bus.out_sel, bus.out_data}, e);
                    end
                end
            end
            if (k > 0) begin
                n_chk++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ctn_bubble k=%0d: got out_valid %b expected 1", k, bus.out_valid);
                end
            end
            if (act) begin
                exp_q.push_back(g ? {1'b1, bus.in1_data} : {1'b0, bus.in0_data});
                if (g) n1++; else n0++;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ctn_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n0 = 0, n1 = 0;
        logic g, act, ordy;
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            act = k < 9;
            ordy = !(k >= 1 && k <= 3);
            g = k >= 7;
            bus.out_ready = ordy;
            bus.in0_valid = act;
            bus.in1_valid = act && k > 0;
            bus.in0_data = 8'h42 + 8'(n0);
            bus.in1_data = 8'hB0 + 8'(n1);
            #1;
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready} !== {act && ordy && !g, act && ordy && g}) begin
                n_fail++;
                $display("FAIL bp_ready k=%0d: got %b%b expected %b%b", k, bus.in0_ready, bus.in1_ready, act && ordy && !g, act && ordy && g);
            end
            if (!ordy) begin
                n_chk++;
                if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h42}) begin
                    n_fail++;
                    $display("FAIL bp_hold k=%0d: got v=%b d=%h expected v=1 d=42", k, bus.out_valid, bus.out_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_out: got beat %h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_sel, bus.out_data} !== e) begin
                        n_fail++;
                        $display("FAIL bp_out k=%0d: got %h expected %h", k, {bus.out_sel, bus.out_data}, e);
                    end
                end
            end
            if (act && ordy) begin
                exp_q.push_back(g ? {1'b1, bus.in1_data} : {1'b0, bus.in0_data});
                if (g) n1++; else n0++;
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_early_release();
        int n0 = 0, n1 = 0;
        logic g, act;
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            act = k < 5;
            g = k >= 2;
            bus.in0_valid = act && k != 2;
            bus.in1_valid = act;
            bus.in0_data = 8'h60 + 8'(n0);
            bus.in1_data = 8'h70 + 8'(n1);
            #1;
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready} !== {act && !g, act && g}) begin
                n_fail++;
                $display("FAIL er_ready k=%0d: got %b%b expected %b%b", k, bus.in0_ready, bus.in1_ready, act && !g, act && g);
            end
            if (k == 3) begin
                n_chk++;
                if ({bus.out_valid, bus.out_sel} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL er_switch: got v=%b s=%b expected 11", bus.out_valid, bus.out_sel);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL er_out: got beat %h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_sel, bus.out_data} !== e) begin
                        n_fail++;
                        $display("FAIL er_out k=%0d: got %h expected %h", k, {bus.out_sel, bus.out_data}, e);
                    end
                end
            end else if (k > 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL er_bubble k=%0d: got out_valid %b expected 1", k, bus.out_valid);
            end
            if (act) begin
                exp_q.push_back(g ? {1'b1, bus.in1_data} : {1'b0, bus.in0_data});
                if (g) n1++; else n0++;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL er_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.in0_valid = 1'b1;
            bus.in0_data = 8'hC0 + 8'(k);
            #1;
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            exp_q.push_back({1'b0, bus.in0_data});
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_rst_ready: got %b%b expected 00", bus.in0_ready, bus.in1_ready);
        end
`ifdef ARB_STATS_EN
        n_chk++;
        if (beats0 !== 16'd5) begin
            n_fail++;
            $display("FAIL mid_beats0_pre: got %0d expected 5", beats0);
        end
`endif
        @(posedge clk);
        #1;
        n_chk++;
        if ({bus.out_valid, bus.out_data, bus.out_sel} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_rst_state: got v=%b d=%h s=%b expected v=0 d=00 s=1", bus.out_valid, bus.out_data, bus.out_sel);
        end
`ifdef ARB_STATS_EN
        n_chk++;
        if (beats0 !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_beats0_clr: got %0d expected 0", beats0);
        end
`endif
        rst = 1'b0;
        bus.in0_valid = 1'b0;
        exp_q.delete();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_saturation();
        do_reset();
        bus.in0_valid = 1'b1;
        repeat (66000) @(posedge clk);
        #1;
        n_chk++;
        if ({beats0, beats1} !== {16'hFFFF, 16'h0000}) begin
            n_fail++;
            $display("FAIL sat: got %h/%h expected ffff/0000", beats0, beats1);
        end
        bus.in0_valid = 1'b0;
    endtask
`endif

    initial begin
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data = '0;
        bus.in1_data = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_reset_mid_burst();
`ifdef ARB_STATS_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
